// File: rtl/dmem_arbiter_if.sv
// Bundle of core load/store, host loader and RAM signals around the data-RAM arbiter.
// slave = arbiter side; master = the surrounding core/host/RAM environment.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              core_rd;
  logic              core_wr;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;
  logic              err;

  modport slave (
    input  core_rd, core_wr, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_done,
    output ram_addr, ram_wdata, ram_re, ram_we,
    input  ram_rdata, ram_ready,
    output err
  );

  modport master (
    output core_rd, core_wr, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_done,
    input  ram_addr, ram_wdata, ram_re, ram_we,
    output ram_rdata, ram_ready,
    input  err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data RAM between the core load/store port and the host port; IDLE->ACCESS->WAIT->DONE.
// Define DMEM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed core priority.
module dmem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic              r_owner;  // 1 = host owns the current access
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_host_rdata;

  logic              w_core_req;
  logic              w_any_req;
  logic              w_grant_host;
  logic              w_busy;
  logic [7:0]        w_cnt_inc;
  logic              w_abort;
  logic              w_finish;
  logic [DATA_W-1:0] w_ret_data;
  logic              w_ram_re;
  logic              w_ram_we;
  logic              w_core_cmp;
  logic              w_host_done;

  assign w_core_req = bus.core_rd | bus.core_wr;
  assign w_any_req  = w_core_req | bus.host_req;
  assign w_busy     = (r_state == S_ACCESS) || (r_state == S_WAIT);
  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_abort    = (r_state == S_WAIT) && !bus.ram_ready && (w_cnt_inc == 8'(TIMEOUT));
  assign w_finish   = (w_busy && bus.ram_ready) || w_abort;
  assign w_ret_data = w_abort ? {DATA_W{1'b1}} : bus.ram_rdata;

`ifdef DMEM_ARB_RR_EN
  logic r_last;  // 1 = host was granted last
  assign w_grant_host = bus.host_req & (~w_core_req | ~r_last);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      r_last <= 1'b1;
    else if (r_state == S_IDLE && w_any_req)
      r_last <= w_grant_host;
  end
`else
  assign w_grant_host = bus.host_req & ~w_core_req;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: w_next = bus.ram_ready ? S_DONE : S_WAIT;
      S_WAIT:   if (w_finish) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ram_re    = w_busy && !r_we;
    w_ram_we    = w_busy && r_we;
    w_core_cmp  = (r_state == S_DONE) && !r_owner;
    w_host_done = (r_state == S_DONE) && r_owner;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt        <= 8'd0;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_core_rdata <= '0;
      r_host_rdata <= '0;
    end else begin
      r_cnt <= (r_state == S_WAIT) ? w_cnt_inc : 8'd0;
      if (r_state == S_IDLE && w_any_req) begin
        r_owner     <= w_grant_host;
        r_we        <= w_grant_host ? bus.host_we    : bus.core_wr;
        r_ram_addr  <= w_grant_host ? bus.host_addr  : bus.core_addr;
        r_ram_wdata <= w_grant_host ? bus.host_wdata : bus.core_wdata;
      end
      // Writes return nothing, so the owner's read data only moves on a finished read
      if (w_finish && !r_we) begin
        if (r_owner)
          r_host_rdata <= w_ret_data;
        else
          r_core_rdata <= w_ret_data;
      end
      if (w_abort)
        r_err <= 1'b1;
    end
  end

  assign bus.ram_re     = w_ram_re;
  assign bus.ram_we     = w_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.core_rdata = r_core_rdata;
  assign bus.core_stall = w_core_req & ~w_core_cmp;
  assign bus.host_rdata = r_host_rdata;
  assign bus.host_done  = w_host_done;
  assign bus.err        = r_err;
endmodule
